ldm_writeback_sequencer: RTL and testbench
==========================================

Name: ldm_writeback_sequencer

Overview:
- Drives the register file write port (reg_write_en / write_reg_addr / write_data) for block loads: one command carries a 16-bit register list; the block consumes one memory word per listed register and writes them in ascending register order.
- Optionally writes back the updated base register afterwards.
- Sits in the writeback stage, between the memory-data return path and the register file.

Parameters:
- DATA_W, 32, data word width
- NUM_REGS, 16, number of architectural registers (width of register list)
- ADDR_W, 4, register address width (clog2 NUM_REGS)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept command (high only in IDLE)
- cmd_reg_list  in  NUM_REGS  bit i set = load Ri
- cmd_base_reg  in  ADDR_W  base register number
- cmd_base_value  in  DATA_W  current base register value
- cmd_writeback  in  1  update base register after loads
- cmd_up  in  1  1 = base += 4*count, 0 = base -= 4*count
- mem_valid  in  1  memory data word available
- mem_ready  out  1  block consumes word (high only in LOAD)
- mem_data  in  DATA_W  memory data word
- reg_write_en  out  1  register file write enable
- write_reg_addr  out  ADDR_W  register file write address
- write_data  out  DATA_W  register file write data
- busy  out  1  high in any state but IDLE
- done  out  1  one-cycle pulse at command completion

Behaviour:
- All outputs registered. On reset_n low (any time, mid-command included), immediately: state IDLE, latched list cleared, reg_write_en/write_reg_addr/write_data/done/busy = 0, mem_ready = 0, cmd_ready = 1 after release. A half-finished command is abandoned; no further writes.
- States: IDLE, LOAD, WB, DONE.
- IDLE: cmd_valid & cmd_ready latches list, base reg/value, writeback, up; popcount latched as count (0..16).
  - Non-empty list -> LOAD.
  - Empty list -> WB if cmd_writeback, else DONE.
- LOAD: mem_ready = 1. On mem_valid & mem_ready:
  - Lowest set bit k of the remaining list is cleared.
  - Next cycle: reg_write_en = 1, write_reg_addr = k, write_data = mem_data.
  - Exception: k = 0 (R0 hardwired zero) → word consumed, reg_write_en held 0.
  - When the cleared bit was the last one: -> WB if cmd_writeback and base register not in original list, else DONE.
  - mem_valid low → stall, no write, reg_write_en 0. Max throughput one word/cycle.
- WB: one cycle. reg_write_en = 1, write_reg_addr = base reg, write_data = base_value + 4*count (up) or base_value - 4*count (down), modulo 2^32 (wraps silently).
  - Base register in list → WB skipped, loaded value wins.
  - Base = R0 → reg_write_en held 0.
  - Transition -> DONE.
- DONE: done = 1 for one cycle, -> IDLE. New commands are not accepted in DONE; cmd_ready stays low.
- Latency: the register write appears on the cycle after the mem handshake. Minimum command duration is count + 2 cycles (+1 with WB).
- reg_write_en is never high for two targets in one cycle. Address/data hold their last value when enable is 0; only enable is meaningful.

Decomposition:
- Shared header cpu_defs.vh holds:
  - state encodings (IDLE=2'd0, LOAD=2'd1, WB=2'd2, DONE=2'd3)
  - WORD_BYTES=4
  - REG_ZERO=4'd0
  - DATA_W/ADDR_W/NUM_REGS defaults
- Sub-module lsb_priority_encoder: NUM_REGS-bit vector in → index of lowest set bit plus "none" flag, combinational. It is reused by the decode stage.

Test Plan:
- Reset, list 16'h0026, base R13 = 32'h0000_1000, up, writeback, mem words 11,22,33 back-to-back → writes R1=11, R2=22, R5=33 on consecutive cycles, then R13=32'h0000_100C, done pulse, cmd_ready=1.
- List 16'h2004 containing base R13, base 32'h100, writeback → R2 and R13 get the memory words; no base write; done after 2 data writes.
- List 16'h0011, mem_valid low for 3 cycles between words → mem word goes to R0 with no write issued; R4 written once after the stall; no spurious reg_write_en during the stall.
- Empty list, base R3 = 32'h0000_0004, down, writeback → no mem_ready, single write R3=32'h0000_0004, done.
- Down wrap: list 16'h0002, base R6 = 32'h0000_0000 → R1 written, then R6=32'hFFFF_FFFC.
- reset_n pulsed low after first of 3 words → outputs 0 immediately, no remaining writes, IDLE with cmd_ready=1 after release; new command then runs normally.

Source files
------------

// File: rtl/ldm_writeback_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ldm_writeback_sequencer_pkg
//  Description : Shared definitions for the block-load writeback sequencer:
//                FSM state encoding, word size and register defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package ldm_writeback_sequencer_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 16;
  localparam int DEF_ADDR_W   = 4;

  // Bytes per memory word; the base register moves by this much per load.
  localparam int WORD_BYTES = 4;

  // R0 is hardwired to zero, so writes to it are suppressed.
  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WB   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ldm_writeback_sequencer_lsb_priority_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : lsb_priority_encoder
//  Description : Combinational index of the lowest set bit of a vector, with
//                a flag for the all-zero case. Shared with the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsb_priority_encoder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         none_o
);

  // Scan from the top down so the lowest set bit is the last one to win.
  always_comb begin
    idx_o  = '0;
    none_o = 1'b1;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o  = W'(i);
        none_o = 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ldm_writeback_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ldm_writeback_sequencer
//  Description : Writeback-stage sequencer for block loads. Takes one memory
//                word per listed register, writes registers in ascending
//                order, then optionally writes back the updated base.
//  Revision    : 1.0 - initial release
// ============================================================================
module ldm_writeback_sequencer
  import ldm_writeback_sequencer_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [NUM_REGS-1:0] cmd_reg_list,
  input  logic [ADDR_W-1:0]   cmd_base_reg,
  input  logic [DATA_W-1:0]   cmd_base_value,
  input  logic                cmd_writeback,
  input  logic                cmd_up,
  input  logic                mem_valid,
  output logic                mem_ready,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                reg_write_en,
  output logic [ADDR_W-1:0]   write_reg_addr,
  output logic [DATA_W-1:0]   write_data,
  output logic                busy,
  output logic                done
);

  localparam int CNT_W = $clog2(NUM_REGS + 1);

  state_e                state_q, state_d;
  logic [NUM_REGS-1:0]   list_q, list_d;
  logic [ADDR_W-1:0]     base_reg_q, base_reg_d;
  logic [DATA_W-1:0]     base_val_q, base_val_d;
  logic                  wb_q, wb_d;
  logic                  up_q, up_d;
  logic                  skip_wb_q, skip_wb_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  cmd_ready_q, cmd_ready_d;
  logic                  mem_ready_q, mem_ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     waddr_q, waddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;

  logic [ADDR_W-1:0]     low_idx;
  logic                  list_none;
  logic [NUM_REGS-1:0]   list_clr;
  logic [CNT_W-1:0]      pop_cnt;
  logic [DATA_W-1:0]     offset;
  logic [DATA_W-1:0]     wb_value;

  lsb_priority_encoder #(
    .N (NUM_REGS),
    .W (ADDR_W)
  ) u_lsb_enc (
    .vec_i  (list_q),
    .idx_o  (low_idx),
    .none_o (list_none)
  );

  assign list_clr = list_q & ~(NUM_REGS'(1) << low_idx);
  assign offset   = DATA_W'(count_q) * DATA_W'(WORD_BYTES);
  assign wb_value = up_q ? (base_val_q + offset) : (base_val_q - offset);

  // Number of registers named by the incoming command.
  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      pop_cnt = pop_cnt + CNT_W'(cmd_reg_list[i]);
    end
  end

  // Next-state, command latching and registered-output computation.
  always_comb begin
    state_d    = state_q;
    list_d     = list_q;
    base_reg_d = base_reg_q;
    base_val_d = base_val_q;
    wb_d       = wb_q;
    up_d       = up_q;
    skip_wb_d  = skip_wb_q;
    count_d    = count_q;
    we_d       = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          list_d     = cmd_reg_list;
          base_reg_d = cmd_base_reg;
          base_val_d = cmd_base_value;
          wb_d       = cmd_writeback;
          up_d       = cmd_up;
          count_d    = pop_cnt;
          // A base register that is also loaded keeps the loaded value.
          skip_wb_d  = cmd_reg_list[cmd_base_reg];
          if (cmd_reg_list != '0) begin
            state_d = ST_LOAD;
          end else if (cmd_writeback) begin
            state_d = ST_WB;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (mem_valid && mem_ready_q && !list_none) begin
          list_d = list_clr;
          if (low_idx != ADDR_W'(REG_ZERO)) begin
            we_d    = 1'b1;
            waddr_d = low_idx;
            wdata_d = mem_data;
          end
          if (list_clr == '0) begin
            state_d = (wb_q && !skip_wb_q) ? ST_WB : ST_DONE;
          end
        end
      end
      ST_WB: begin
        if (base_reg_q != ADDR_W'(REG_ZERO)) begin
          we_d    = 1'b1;
          waddr_d = base_reg_q;
          wdata_d = wb_value;
        end
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
    mem_ready_d = (state_d == ST_LOAD);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_d == ST_DONE);
  end

  // State, latched command and output registers; reset abandons any command.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      list_q      <= '0;
      base_reg_q  <= '0;
      base_val_q  <= '0;
      wb_q        <= 1'b0;
      up_q        <= 1'b0;
      skip_wb_q   <= 1'b0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
      mem_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      list_q      <= list_d;
      base_reg_q  <= base_reg_d;
      base_val_q  <= base_val_d;
      wb_q        <= wb_d;
      up_q        <= up_d;
      skip_wb_q   <= skip_wb_d;
      count_q     <= count_d;
      cmd_ready_q <= cmd_ready_d;
      mem_ready_q <= mem_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign mem_ready      = mem_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign reg_write_en   = we_q;
  assign write_reg_addr = waddr_q;
  assign write_data     = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ldm_writeback_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ldm_writeback_sequencer
//  Description : Self-checking bench for ldm_writeback_sequencer. Expected
//                register writes and completion timing come from a queue
//                model built directly from each command.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ldm_writeback_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_reg_list;
  logic [3:0]  cmd_base_reg;
  logic [31:0] cmd_base_value;
  logic        cmd_writeback;
  logic        cmd_up;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        reg_write_en;
  logic [3:0]  write_reg_addr;
  logic [31:0] write_data;
  logic        busy;
  logic        done;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] r_list;
  logic [3:0]  r_base;

  always #5 clk = ~clk;

  ldm_writeback_sequencer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_reg_list   (cmd_reg_list),
    .cmd_base_reg   (cmd_base_reg),
    .cmd_base_value (cmd_base_value),
    .cmd_writeback  (cmd_writeback),
    .cmd_up         (cmd_up),
    .mem_valid      (mem_valid),
    .mem_ready      (mem_ready),
    .mem_data       (mem_data),
    .reg_write_en   (reg_write_en),
    .write_reg_addr (write_reg_addr),
    .write_data     (write_data),
    .busy           (busy),
    .done           (done)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command, feed its memory words and compare every register
  // write against the model. stall_pct < 0 means: stall 3 cycles after the
  // first word. abort_after > 0 pulses reset after that many writes.
  task automatic run_cmd(input string tag, input logic [15:0] list, input logic [3:0] base,
                         input logic [31:0] bval, input bit wb, input bit up,
                         input int stall_pct, input bit seq_words, input int abort_after);
    logic [31:0] words[$];
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    logic [31:0] w;
    logic [31:0] d;
    int          a;
    int          cnt;
    int          idx;
    int          last_hs;
    int          seen;
    int          hold;
    bit          wbs;
    bit          got_done;

    cnt = 0; idx = 0; last_hs = 0; seen = 0; hold = 0; got_done = 0;
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        w = seq_words ? 32'(11 * (cnt + 1)) : $urandom;
        words.push_back(w);
        if (i != 0) begin
          exp_addr.push_back(i);
          exp_data.push_back(w);
        end
        cnt++;
      end
    end
    wbs = wb && !list[base];
    if (wbs && base != 4'd0) begin
      exp_addr.push_back(int'(base));
      exp_data.push_back(up ? bval + 32'(4 * cnt) : bval - 32'(4 * cnt));
    end

    @(negedge clk);
    check_eq({tag, "/cmd_ready_idle"}, 64'(cmd_ready), 64'd1);
    cmd_valid      = 1'b1;
    cmd_reg_list   = list;
    cmd_base_reg   = base;
    cmd_base_value = bval;
    cmd_writeback  = wb;
    cmd_up         = up;
    @(negedge clk);
    cmd_valid      = 1'b0;
    cmd_reg_list   = 16'($urandom);
    cmd_base_value = $urandom;

    for (int it = 1; it <= 300; it++) begin
      if (it > 1) @(negedge clk);
      if (it == 1) begin
        check_eq({tag, "/busy_active"}, 64'(busy), 64'd1);
        check_eq({tag, "/cmd_ready_busy"}, 64'(cmd_ready), 64'd0);
      end
      if (reg_write_en) begin
        seen++;
        if (exp_addr.size() == 0) begin
          check_eq({tag, "/spurious_we"}, 64'(reg_write_en), 64'd0);
        end else begin
          a = exp_addr.pop_front();
          d = exp_data.pop_front();
          check_eq({tag, "/waddr"}, 64'(write_reg_addr), 64'(a));
          check_eq({tag, "/wdata"}, 64'(write_data), 64'(d));
        end
      end
      if (list == 16'h0 && mem_ready) begin
        check_eq({tag, "/mem_ready_empty"}, 64'(mem_ready), 64'd0);
      end
      if (done) begin
        got_done = 1'b1;
        check_eq({tag, "/done_cycle"}, 64'(it), 64'(last_hs + 1 + int'(wbs)));
        check_eq({tag, "/writes_left"}, 64'(exp_addr.size()), 64'd0);
        break;
      end
      if (abort_after > 0 && seen == abort_after) begin
        mem_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_eq({tag, "/rst_we"}, 64'(reg_write_en), 64'd0);
        check_eq({tag, "/rst_addr"}, 64'(write_reg_addr), 64'd0);
        check_eq({tag, "/rst_data"}, 64'(write_data), 64'd0);
        check_eq({tag, "/rst_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "/rst_done"}, 64'(done), 64'd0);
        check_eq({tag, "/rst_mem_ready"}, 64'(mem_ready), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          mem_valid = 1'b1;
          mem_data  = $urandom;
          @(negedge clk);
          if (reg_write_en) check_eq({tag, "/post_rst_we"}, 64'(reg_write_en), 64'd0);
        end
        mem_valid = 1'b0;
        check_eq({tag, "/post_rst_cmd_ready"}, 64'(cmd_ready), 64'd1);
        check_eq({tag, "/post_rst_busy"}, 64'(busy), 64'd0);
        return;
      end
      mem_valid = 1'b0;
      mem_data  = $urandom;
      if (mem_ready && idx < words.size()) begin
        if (stall_pct < 0 && idx == 1 && hold < 3) begin
          hold++;
        end else if (int'($urandom_range(99)) >= stall_pct) begin
          mem_valid = 1'b1;
          mem_data  = words[idx];
          idx++;
          last_hs   = it;
        end
      end
    end
    mem_valid = 1'b0;
    check_eq({tag, "/done_seen"}, 64'(got_done), 64'd1);
    @(negedge clk);
    check_eq({tag, "/done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, "/cmd_ready_after"}, 64'(cmd_ready), 64'd1);
    check_eq({tag, "/busy_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n        = 1'b0;
    cmd_valid      = 1'b0;
    cmd_reg_list   = '0;
    cmd_base_reg   = '0;
    cmd_base_value = '0;
    cmd_writeback  = 1'b0;
    cmd_up         = 1'b0;
    mem_valid      = 1'b0;
    mem_data       = '0;
    #1;
    check_eq("reset/we", 64'(reg_write_en), 64'd0);
    check_eq("reset/addr", 64'(write_reg_addr), 64'd0);
    check_eq("reset/data", 64'(write_data), 64'd0);
    check_eq("reset/busy", 64'(busy), 64'd0);
    check_eq("reset/done", 64'(done), 64'd0);
    check_eq("reset/mem_ready", 64'(mem_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_eq("reset/cmd_ready", 64'(cmd_ready), 64'd1);

    run_cmd("basic_up_wb",  16'h0026, 4'd13, 32'h0000_1000, 1'b1, 1'b1, 0,  1'b1, 0);
    run_cmd("base_in_list", 16'h2004, 4'd13, 32'h0000_0100, 1'b1, 1'b1, 0,  1'b1, 0);
    run_cmd("r0_stall",     16'h0011, 4'd2,  32'h0000_0040, 1'b0, 1'b1, -1, 1'b0, 0);
    run_cmd("empty_wb",     16'h0000, 4'd3,  32'h0000_0004, 1'b1, 1'b0, 0,  1'b0, 0);
    run_cmd("empty_nowb",   16'h0000, 4'd3,  32'h0000_0004, 1'b0, 1'b0, 0,  1'b0, 0);
    run_cmd("down_wrap",    16'h0002, 4'd6,  32'h0000_0000, 1'b1, 1'b0, 0,  1'b0, 0);
    run_cmd("base_r0",      16'h0100, 4'd0,  32'h0000_2000, 1'b1, 1'b1, 0,  1'b0, 0);
    run_cmd("full_list",    16'hFFFF, 4'd9,  32'h1234_5678, 1'b1, 1'b0, 0,  1'b0, 0);
    run_cmd("abort",        16'h0E00, 4'd1,  32'h0000_0800, 1'b1, 1'b1, 0,  1'b1, 1);
    run_cmd("after_abort",  16'h00F0, 4'd12, 32'h0000_0800, 1'b1, 1'b1, 0,  1'b1, 0);

    for (int n = 0; n < 40; n++) begin
      r_list = 16'($urandom) & 16'($urandom | $urandom);
      if (n % 5 == 0) r_list = 16'h0000;
      if (n % 7 == 3) r_list = 16'hFFFF;
      r_base = 4'($urandom);
      run_cmd($sformatf("rnd%0d", n), r_list, r_base, $urandom, 1'($urandom), 1'($urandom),
              int'($urandom_range(60)), 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
